// File: rtl/axi_arbiter_if.sv
// AXI4-Lite bundle; master drives requests, slave drives readies and responses.
interface axi_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic            arvalid;
   logic            arready;
   logic [AW-1:0]   araddr;
   logic            rvalid;
   logic            rready;
   logic [DW-1:0]   rdata;
   logic [1:0]      rresp;
   logic            awvalid;
   logic            awready;
   logic [AW-1:0]   awaddr;
   logic            wvalid;
   logic            wready;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic            bvalid;
   logic            bready;
   logic [1:0]      bresp;

   modport master (
      output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
      input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
   );

   modport slave (
      input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
      output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
   );
endinterface

// File: rtl/axi_arbiter.sv
// 2:1 AXI4-Lite arbiter, independent read/write FSMs; grant 1 cycle after request, mux paths combinational.
// Ungranted master sees all ready/valid low, so its request waits; a stalled rready/bready stalls only its channel.
module axi_arbiter #(
   parameter bit ROUND_ROBIN = 1'b1
) (
   input logic          aclk,
   input logic          aresetn,
   axi_arbiter_if.slave  s0,
   axi_arbiter_if.slave  s1,
   axi_arbiter_if.master m
);

   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_t;

   r_state_t r_state, r_next;
   w_state_t w_state, w_next;
   logic     gr, gr_next, r_pri, r_pri_next;
   logic     gw, gw_next, w_pri, w_pri_next;

   logic sel_arvalid, sel_rready, sel_awvalid, sel_wvalid, sel_bready;
   logic w_req0, w_req1, w_join;
   logic r_arready, r_rvalid, w_aw_rdy, w_bvalid;

   assign sel_arvalid = gr ? s1.arvalid : s0.arvalid;
   assign sel_rready  = gr ? s1.rready  : s0.rready;
   assign sel_awvalid = gw ? s1.awvalid : s0.awvalid;
   assign sel_wvalid  = gw ? s1.wvalid  : s0.wvalid;
   assign sel_bready  = gw ? s1.bready  : s0.bready;

   // A write request is either half; the FSM then waits for both halves together.
   assign w_req0 = s0.awvalid | s0.wvalid;
   assign w_req1 = s1.awvalid | s1.wvalid;
   assign w_join = sel_awvalid & sel_wvalid;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state <= R_IDLE;
         w_state <= W_IDLE;
         gr      <= 1'b0;
         gw      <= 1'b0;
         r_pri   <= 1'b0;
         w_pri   <= 1'b0;
      end else begin
         r_state <= r_next;
         w_state <= w_next;
         gr      <= gr_next;
         gw      <= gw_next;
         r_pri   <= r_pri_next;
         w_pri   <= w_pri_next;
      end
   end

   always_comb begin
      r_next     = r_state;
      gr_next    = gr;
      r_pri_next = r_pri;
      m.arvalid  = 1'b0;
      m.rready   = 1'b0;
      r_arready  = 1'b0;
      r_rvalid   = 1'b0;
      case (r_state)
         R_IDLE: begin
            if (s0.arvalid || s1.arvalid) begin
               gr_next = (s0.arvalid && s1.arvalid) ? r_pri : s1.arvalid;
               r_next  = R_ADDR;
            end
         end
         R_ADDR: begin
            m.arvalid = sel_arvalid;
            r_arready = m.arready;
            if (sel_arvalid && m.arready) r_next = R_DATA;
         end
         R_DATA: begin
            r_rvalid = m.rvalid;
            m.rready = sel_rready;
            if (m.rvalid && sel_rready) begin
               r_next = R_IDLE;
               if (ROUND_ROBIN) r_pri_next = ~gr;
            end
         end
         default: r_next = R_IDLE;
      endcase
   end

   always_comb begin
      w_next     = w_state;
      gw_next    = gw;
      w_pri_next = w_pri;
      m.awvalid  = 1'b0;
      m.wvalid   = 1'b0;
      m.bready   = 1'b0;
      w_aw_rdy   = 1'b0;
      w_bvalid   = 1'b0;
      case (w_state)
         W_IDLE: begin
            if (w_req0 || w_req1) begin
               gw_next = (w_req0 && w_req1) ? w_pri : w_req1;
               w_next  = W_ADDR;
            end
         end
         W_ADDR: begin
            m.awvalid = w_join;
            m.wvalid  = w_join;
            w_aw_rdy  = m.awready & m.wready & w_join;
            if (w_aw_rdy) w_next = W_RESP;
         end
         W_RESP: begin
            w_bvalid = m.bvalid;
            m.bready = sel_bready;
            if (m.bvalid && sel_bready) begin
               w_next = W_IDLE;
               if (ROUND_ROBIN) w_pri_next = ~gw;
            end
         end
         default: w_next = W_IDLE;
      endcase
   end

   assign m.araddr = gr ? s1.araddr : s0.araddr;
   assign m.awaddr = gw ? s1.awaddr : s0.awaddr;
   assign m.wdata  = gw ? s1.wdata  : s0.wdata;
   assign m.wstrb  = gw ? s1.wstrb  : s0.wstrb;

   // Response data is broadcast; only the valids are steered to the granted master.
   assign s0.arready = r_arready & ~gr;
   assign s1.arready = r_arready &  gr;
   assign s0.rvalid  = r_rvalid  & ~gr;
   assign s1.rvalid  = r_rvalid  &  gr;
   assign s0.rdata   = m.rdata;
   assign s1.rdata   = m.rdata;
   assign s0.rresp   = m.rresp;
   assign s1.rresp   = m.rresp;

   assign s0.awready = w_aw_rdy & ~gw;
   assign s1.awready = w_aw_rdy &  gw;
   assign s0.wready  = w_aw_rdy & ~gw;
   assign s1.wready  = w_aw_rdy &  gw;
   assign s0.bvalid  = w_bvalid & ~gw;
   assign s1.bvalid  = w_bvalid &  gw;
   assign s0.bresp   = m.bresp;
   assign s1.bresp   = m.bresp;

endmodule

// File: tb/tb_axi_arbiter.sv
// Directed bench: round-robin arbiter with a small RAM model, plus a fixed-priority instance.
module tb_axi_arbiter;

   logic aclk = 1'b0;
   logic aresetn;
   always #5 aclk = ~aclk;

   axi_arbiter_if i0 (), i1 (), im ();
   axi_arbiter_if j0 (), j1 (), jm ();

   axi_arbiter #(.ROUND_ROBIN(1'b1)) dut (
      .aclk(aclk), .aresetn(aresetn), .s0(i0), .s1(i1), .m(im)
   );

   axi_arbiter #(.ROUND_ROBIN(1'b0)) dut_fixed (
      .aclk(aclk), .aresetn(aresetn), .s0(j0), .s1(j1), .m(jm)
   );

   localparam int LIM = 40;

   int checks = 0;
   int errors = 0;
   int rd_order[$];
   bit s1_rv_seen;
   bit overlap_seen;

   // RAM slave for the round-robin instance: always ready, registered rvalid/bvalid.
   logic [31:0] mem [16];
   assign im.arready = 1'b1;
   assign im.awready = 1'b1;
   assign im.wready  = 1'b1;
   assign im.rresp   = 2'b00;
   assign im.bresp   = 2'b00;

   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         im.rvalid <= 1'b0;
         im.bvalid <= 1'b0;
         im.rdata  <= 32'h0;
         for (int a = 0; a < 16; a++) mem[a] <= 32'h0;
         mem[0] <= 32'h1111_1111;
         mem[1] <= 32'h2222_2222;
         mem[4] <= 32'hDEAD_BEEF;
      end else begin
         if (im.arvalid && im.arready) begin
            im.rvalid <= 1'b1;
            im.rdata  <= mem[im.araddr[5:2]];
         end else if (im.rvalid && im.rready) begin
            im.rvalid <= 1'b0;
         end
         if (im.awvalid && im.wvalid) begin
            for (int b = 0; b < 4; b++)
               if (im.wstrb[b]) mem[im.awaddr[5:2]][8*b +: 8] <= im.wdata[8*b +: 8];
            im.bvalid <= 1'b1;
         end else if (im.bvalid && im.bready) begin
            im.bvalid <= 1'b0;
         end
      end
   end

   // Read-only slave for the fixed-priority instance.
   assign jm.arready = 1'b1;
   assign jm.awready = 1'b1;
   assign jm.wready  = 1'b1;
   assign jm.bvalid  = 1'b0;
   assign jm.bresp   = 2'b00;
   assign jm.rresp   = 2'b00;
   assign jm.rdata   = 32'h0;
   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) jm.rvalid <= 1'b0;
      else if (jm.arvalid && jm.arready) jm.rvalid <= 1'b1;
      else if (jm.rvalid && jm.rready) jm.rvalid <= 1'b0;
   end

   logic [14:0] outs_a;
   assign outs_a = {i0.arready, i0.rvalid, i0.awready, i0.wready, i0.bvalid,
                    i1.arready, i1.rvalid, i1.awready, i1.wready, i1.bvalid,
                    im.arvalid, im.rready, im.awvalid, im.wvalid, im.bready};

   always @(negedge aclk) begin
      #2;
      if (i1.rvalid) s1_rv_seen = 1'b1;
      if ((i0.arready || i0.rvalid) && (i1.awready || i1.bvalid)) overlap_seen = 1'b1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: no handshake within %0d cycles, expected one", name, LIM);
   endtask

   task automatic clear_inputs();
      i0.arvalid = 0; i0.araddr = 0; i0.rready = 0; i0.awvalid = 0; i0.awaddr = 0;
      i0.wvalid = 0; i0.wdata = 0; i0.wstrb = 0; i0.bready = 0;
      i1.arvalid = 0; i1.araddr = 0; i1.rready = 0; i1.awvalid = 0; i1.awaddr = 0;
      i1.wvalid = 0; i1.wdata = 0; i1.wstrb = 0; i1.bready = 0;
      j0.arvalid = 0; j0.araddr = 0; j0.rready = 0; j0.awvalid = 0; j0.awaddr = 0;
      j0.wvalid = 0; j0.wdata = 0; j0.wstrb = 0; j0.bready = 0;
      j1.arvalid = 0; j1.araddr = 0; j1.rready = 0; j1.awvalid = 0; j1.awaddr = 0;
      j1.wvalid = 0; j1.wdata = 0; j1.wstrb = 0; j1.bready = 0;
   endtask

   task automatic apply_reset();
      clear_inputs();
      aresetn = 1'b0;
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
   endtask

   function automatic logic ar_rdy(input int k);
      return (k == 0) ? i0.arready : i1.arready;
   endfunction
   function automatic logic r_vld(input int k);
      return (k == 0) ? i0.rvalid : i1.rvalid;
   endfunction
   function automatic logic aw_rdy(input int k);
      return (k == 0) ? i0.awready : i1.awready;
   endfunction
   function automatic logic b_vld(input int k);
      return (k == 0) ? i0.bvalid : i1.bvalid;
   endfunction

   // Call at a negedge; returns at the negedge after the response handshake.
   task automatic do_read(input int k, input logic [31:0] addr,
                          output logic [31:0] data, output logic [1:0] resp);
      int n;
      data = 32'h0;
      resp = 2'b11;
      if (k == 0) begin i0.araddr = addr; i0.arvalid = 1; i0.rready = 1; end
      else        begin i1.araddr = addr; i1.arvalid = 1; i1.rready = 1; end
      n = 0;
      #1;
      while (!ar_rdy(k) && n < LIM) begin @(negedge aclk); #1; n++; end
      if (!ar_rdy(k)) timeout($sformatf("rd%0d_arready", k));
      @(negedge aclk);
      if (k == 0) i0.arvalid = 0; else i1.arvalid = 0;
      n = 0;
      while (!r_vld(k) && n < LIM) begin @(negedge aclk); n++; end
      if (!r_vld(k)) timeout($sformatf("rd%0d_rvalid", k));
      else begin
         data = (k == 0) ? i0.rdata : i1.rdata;
         resp = (k == 0) ? i0.rresp : i1.rresp;
         rd_order.push_back(k);
      end
      @(negedge aclk);
      if (k == 0) i0.rready = 0; else i1.rready = 0;
   endtask

   task automatic do_write(input int k, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int wdelay, output logic [1:0] resp);
      int n;
      resp = 2'b11;
      if (k == 0) begin
         i0.awaddr = addr; i0.wdata = data; i0.wstrb = strb;
         i0.awvalid = 1; i0.wvalid = (wdelay == 0); i0.bready = 1;
      end else begin
         i1.awaddr = addr; i1.wdata = data; i1.wstrb = strb;
         i1.awvalid = 1; i1.wvalid = (wdelay == 0); i1.bready = 1;
      end
      for (int i = 0; i < wdelay; i++) begin
         @(negedge aclk);
         #1;
         check($sformatf("join_hold_%0d", i), im.awvalid, 1'b0);
      end
      if (wdelay > 0) begin
         if (k == 0) i0.wvalid = 1; else i1.wvalid = 1;
         #1;
         check("join_forward", im.awvalid & im.wvalid, 1'b1);
      end
      n = 0;
      #1;
      while (!aw_rdy(k) && n < LIM) begin @(negedge aclk); #1; n++; end
      if (!aw_rdy(k)) timeout($sformatf("wr%0d_awready", k));
      @(negedge aclk);
      if (k == 0) begin i0.awvalid = 0; i0.wvalid = 0; end
      else        begin i1.awvalid = 0; i1.wvalid = 0; end
      n = 0;
      while (!b_vld(k) && n < LIM) begin @(negedge aclk); n++; end
      if (!b_vld(k)) timeout($sformatf("wr%0d_bvalid", k));
      else resp = (k == 0) ? i0.bresp : i1.bresp;
      @(negedge aclk);
      if (k == 0) i0.bready = 0; else i1.bready = 0;
   endtask

   typedef struct {
      bit          mst;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #200000;
      $display("FAIL watchdog: still running at %0t, expected completion", $time);
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      logic [1:0]  r;
      int n, c0, c1;

      vecs[0] = '{0, 0, 32'h10, 32'h0,         4'h0,    32'hDEAD_BEEF};
      vecs[1] = '{1, 0, 32'h00, 32'h0,         4'h0,    32'h1111_1111};
      vecs[2] = '{0, 1, 32'h0C, 32'h1234_5678, 4'hF,    32'h0};
      vecs[3] = '{1, 0, 32'h0C, 32'h0,         4'h0,    32'h1234_5678};
      vecs[4] = '{1, 1, 32'h14, 32'hAABB_CCDD, 4'b1100, 32'h0};
      vecs[5] = '{0, 0, 32'h14, 32'h0,         4'h0,    32'hAABB_0000};

      clear_inputs();
      aresetn = 1'b0;
      repeat (2) @(negedge aclk);
      check("reset_outputs", {17'h0, outs_a}, 32'h0);
      aresetn = 1'b1;
      @(negedge aclk);

      // Fixed priority: both request continuously, s0 takes all four.
      j0.araddr = 32'h0; j1.araddr = 32'h4;
      j0.arvalid = 1; j1.arvalid = 1; j0.rready = 1; j1.rready = 1;
      n = 0; c0 = 0; c1 = 0;
      while (c0 + c1 < 4 && n < 60) begin
         @(negedge aclk);
         if (j0.rvalid) c0++;
         if (j1.rvalid) c1++;
         n++;
      end
      j0.arvalid = 0; j1.arvalid = 0;
      @(negedge aclk);
      j0.rready = 0; j1.rready = 0;
      check("fixed_s0_grants", c0, 4);
      check("fixed_s1_grants", c1, 0);

      // Single read: grant latency and isolation of s1.
      s1_rv_seen = 0;
      i0.araddr = 32'h10; i0.arvalid = 1; i0.rready = 1;
      #1;
      check("lat_same_cycle", im.arvalid, 1'b0);
      @(negedge aclk);
      #1;
      check("lat_next_cycle", im.arvalid, 1'b1);
      do_read(0, 32'h10, d, r);
      check("single_rdata", d, 32'hDEAD_BEEF);
      check("single_rresp", r, 2'b00);
      check("single_s1_no_rvalid", s1_rv_seen, 1'b0);

      for (int v = 0; v < 6; v++) begin
         if (vecs[v].wr) begin
            do_write(vecs[v].mst, vecs[v].addr, vecs[v].wdata, vecs[v].wstrb, 0, r);
            check($sformatf("vec%0d_bresp", v), r, 2'b00);
         end else begin
            do_read(vecs[v].mst, vecs[v].addr, d, r);
            check($sformatf("vec%0d_rdata", v), d, vecs[v].exp);
            check($sformatf("vec%0d_rresp", v), r, 2'b00);
         end
      end

      // Write with wvalid two cycles behind awvalid, then read back the strobed word.
      do_write(1, 32'h8, 32'hCAFE_F00D, 4'b0011, 2, r);
      check("join_bresp", r, 2'b00);
      do_read(0, 32'h8, d, r);
      check("join_readback", d, 32'h0000_F00D);

      // Simultaneous requests, then s0 re-requesting against a waiting s1.
      apply_reset();
      rd_order.delete();
      fork
         begin
            logic [31:0] d0;
            logic [1:0]  r0;
            for (int q = 0; q < 3; q++) begin
               do_read(0, 32'h0, d0, r0);
               check("rr_s0_rdata", d0, 32'h1111_1111);
            end
         end
         begin
            logic [31:0] d1;
            logic [1:0]  r1;
            for (int q = 0; q < 2; q++) begin
               do_read(1, 32'h4, d1, r1);
               check("rr_s1_rdata", d1, 32'h2222_2222);
            end
         end
      join
      check("rr_count", rd_order.size(), 5);
      for (int q = 0; q < 5; q++)
         check($sformatf("rr_order_%0d", q), (q < rd_order.size()) ? rd_order[q] : -1, q % 2);

      // Read on s0 overlapping a write on s1.
      overlap_seen = 0;
      fork
         begin
            logic [31:0] d2;
            logic [1:0]  r2;
            do_read(0, 32'h4, d2, r2);
            check("conc_rdata", d2, 32'h2222_2222);
         end
         begin
            logic [1:0] r3;
            do_write(1, 32'h18, 32'h5A5A_A5A5, 4'hF, 0, r3);
            check("conc_bresp", r3, 2'b00);
         end
      join
      check("conc_overlap", overlap_seen, 1'b1);

      // Point read priority at s1, then reset in R_DATA with rready held low.
      do_read(0, 32'h0, d, r);
      i0.araddr = 32'h0; i0.arvalid = 1; i0.rready = 0;
      n = 0;
      #1;
      while (!i0.arready && n < LIM) begin @(negedge aclk); #1; n++; end
      if (!i0.arready) timeout("rst_arready");
      @(negedge aclk);
      i0.arvalid = 0;
      check("rst_pre_rvalid", i0.rvalid, 1'b1);
      #2;
      aresetn = 1'b0;
      #1;
      check("rst_async_outputs", {17'h0, outs_a}, 32'h0);
      clear_inputs();
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
      rd_order.delete();
      fork
         begin
            logic [31:0] d4;
            logic [1:0]  r4;
            do_read(0, 32'h0, d4, r4);
         end
         begin
            logic [31:0] d5;
            logic [1:0]  r5;
            do_read(1, 32'h4, d5, r5);
         end
      join
      check("rst_count", rd_order.size(), 2);
      check("rst_first_grant", (rd_order.size() > 0) ? rd_order[0] : -1, 0);
      check("rst_second_grant", (rd_order.size() > 1) ? rd_order[1] : -1, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
